sm3_stream_hash: RTL and testbench

- Streaming SM3 front end: accepts an arbitrary-length byte message as 32-bit big-endian words over a valid/ready handshake.
- Performs SM3 padding on the fly: 0x80 marker, zero fill, 64-bit bit length.
- Issues each 512-bit block to an external sm3_CF core, chaining the IV, and presents the final 256-bit digest.
- Serves as the general-length message source for the SM3 compression core, replacing hard-coded, pre-packed padding in per-commitment hashers.

---
 rtl/sm3_stream_hash.sv | 157 +++++++++++++++
 tb/tb_sm3_stream_hash.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_stream_hash.sv
// Streaming SM3 front end: packs 32-bit big-endian message words into 512-bit
// blocks, applies SM3 padding on the fly and chains an external sm3_CF core.
//
// state | meaning
// IDLE  | between messages, raises msg_ready next cycle
// LOAD  | accepting message words into the block buffer
// PAD   | writes the 0x80 marker (and the length if it fits)
// LEN   | builds the trailing length-only block
// COMP  | waits for sm3_CF, buffer and IV held stable
// DONE  | publishes the digest, restores the IV
module sm3_stream_hash #(
  parameter logic [255:0] IV_INIT = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e,
  parameter int           LEN_W   = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  msg_data,
  input  logic         msg_valid,
  input  logic         msg_last,
  input  logic [2:0]   msg_bytes,
  output logic         msg_ready,
  output logic         cf_start,
  output logic [255:0] cf_iv,
  output logic [511:0] cf_block,
  input  logic         cf_end,
  input  logic [255:0] cf_hash,
  output logic [255:0] hashValue,
  output logic         en_end
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PAD, S_LEN, S_COMP, S_DONE
  } state_t;

  state_t             r_state;
  state_t             r_ret;
  logic [31:0]        r_w [16];
  logic [4:0]         r_widx;
  logic [LEN_W-1:0]   r_bitcnt;
  logic [2:0]         r_lbytes;
  logic               r_pend;

  logic [2:0]         w_in_bytes;
  logic [4:0]         w_last_idx;
  logic [4:0]         w_mark_idx;
  logic [31:0]        w_cur;
  logic [31:0]        w_mark_word;
  logic               w_accept;

  always_comb begin
    for (int i = 0; i < 16; i++) cf_block[511-32*i -: 32] = r_w[i];
  end

  // Out-of-range byte counts are treated as a full word.
  assign w_in_bytes = !msg_last ? 3'd4 : ((msg_bytes > 3'd4) ? 3'd4 : msg_bytes);
  assign w_accept   = msg_valid && msg_ready;
  assign w_last_idx = r_widx - 5'd1;
  assign w_mark_idx = (r_lbytes == 3'd4) ? r_widx : w_last_idx;
  assign w_cur      = r_w[w_last_idx[3:0]];

  always_comb begin
    w_mark_word = 32'h8000_0000;
    case (r_lbytes)
      3'd1:    w_mark_word = {w_cur[31:24], 24'h80_0000};
      3'd2:    w_mark_word = {w_cur[31:16], 16'h8000};
      3'd3:    w_mark_word = {w_cur[31:8],  8'h80};
      default: w_mark_word = 32'h8000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ret     <= S_LOAD;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      r_widx    <= '0;
      r_bitcnt  <= '0;
      r_lbytes  <= '0;
      r_pend    <= 1'b0;
      msg_ready <= 1'b0;
      cf_start  <= 1'b0;
      cf_iv     <= IV_INIT;
      hashValue <= '0;
      en_end    <= 1'b0;
    end else begin
      en_end <= 1'b0;
      case (r_state)
        S_IDLE: begin
          msg_ready <= 1'b1;
          r_state   <= S_LOAD;
        end
        S_LOAD: begin
          if (w_accept) begin
            r_w[r_widx[3:0]] <= msg_data;
            r_widx           <= r_widx + 5'd1;
            r_bitcnt         <= r_bitcnt + LEN_W'({w_in_bytes, 3'b000});
            r_lbytes         <= w_in_bytes;
            if (msg_last) begin
              msg_ready <= 1'b0;
              r_state   <= S_PAD;
            end else if (r_widx == 5'd15) begin
              msg_ready <= 1'b0;
              cf_start  <= 1'b1;
              r_ret     <= S_LOAD;
              r_state   <= S_COMP;
            end
          end
        end
        S_PAD: begin
          cf_start <= 1'b1;
          r_state  <= S_COMP;
          if (w_mark_idx <= 5'd13) begin
            r_w[w_mark_idx[3:0]] <= w_mark_word;
            r_w[14]              <= r_bitcnt[63:32];
            r_w[15]              <= r_bitcnt[31:0];
            r_ret                <= S_DONE;
          end else if (w_mark_idx <= 5'd15) begin
            r_w[w_mark_idx[3:0]] <= w_mark_word;
            r_ret                <= S_LEN;
          end else begin
            // Full final block: the marker opens the length block instead.
            r_pend <= 1'b1;
            r_ret  <= S_LEN;
          end
        end
        S_LEN: begin
          r_w[0]   <= r_pend ? 32'h8000_0000 : 32'h0;
          r_w[14]  <= r_bitcnt[63:32];
          r_w[15]  <= r_bitcnt[31:0];
          r_pend   <= 1'b0;
          cf_start <= 1'b1;
          r_ret    <= S_DONE;
          r_state  <= S_COMP;
        end
        S_COMP: begin
          if (cf_end) begin
            cf_start <= 1'b0;
            cf_iv    <= cf_hash;
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            r_widx   <= '0;
            r_state  <= r_ret;
            if (r_ret == S_LOAD) msg_ready <= 1'b1;
          end
        end
        S_DONE: begin
          hashValue <= cf_iv;
          en_end    <= 1'b1;
          cf_iv     <= IV_INIT;
          r_bitcnt  <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_stream_hash.sv
// Directed bench for sm3_stream_hash with a behavioural SM3 compression core
// answering the cf_start/cf_end handshake.
module tb_sm3_stream_hash;

  localparam logic [255:0] IV = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [255:0] D_ABC   = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] D_ABCD  = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;
  localparam logic [255:0] D_EMPTY = 256'h1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  msg_data;
  logic         msg_valid;
  logic         msg_last;
  logic [2:0]   msg_bytes;
  logic         msg_ready;
  logic         cf_start;
  logic [255:0] cf_iv;
  logic [511:0] cf_block;
  logic         cf_end;
  logic [255:0] cf_hash;
  logic [255:0] hashValue;
  logic         en_end;

  int n_checks = 0;
  int n_err    = 0;
  int cf_lat   = 2;

  int            en_cnt    = 0;
  int            start_cnt = 0;
  int            stab_err  = 0;
  int            comp_acc  = 0;
  logic          p_start   = 1'b0;
  logic [511:0]  p_blk     = '0;
  logic [255:0]  p_iv      = '0;
  logic [511:0]  blk_log [8];

  sm3_stream_hash dut (
    .clk(clk), .reset(reset),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_bytes(msg_bytes), .msg_ready(msg_ready),
    .cf_start(cf_start), .cf_iv(cf_iv), .cf_block(cf_block),
    .cf_end(cf_end), .cf_hash(cf_hash),
    .hashValue(hashValue), .en_end(en_end)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 9) ^ rotl(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w [68];
    logic [31:0] w1 [64];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, tj, ff, gg;
    for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg  = (j < 16) ? (e ^ f ^ g)  : ((e & f) | (~e & g));
      ss1 = rotl(rotl(a, 12) + e + rotl(tj, j), 7);
      ss2 = ss1 ^ rotl(a, 12);
      tt1 = ff + d + ss2 + w1[j];
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rotl(bb, 9); bb = a; a = tt1;
      h = g; g = rotl(f, 19); f = e; e = p0(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  // Compression core model: answers cf_start after cf_lat cycles, abandons on drop.
  initial begin
    cf_end  = 1'b0;
    cf_hash = '0;
    forever begin
      @(negedge clk);
      if (reset && cf_start) begin
        bit alive;
        alive = 1'b1;
        for (int i = 0; i < cf_lat; i++) begin
          @(negedge clk);
          if (!cf_start || !reset) begin
            alive = 1'b0;
            break;
          end
        end
        if (alive) begin
          cf_hash = sm3_cf(cf_iv, cf_block);
          cf_end  = 1'b1;
          @(negedge clk);
          cf_end  = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    p_start <= cf_start;
    p_blk   <= cf_block;
    p_iv    <= cf_iv;
    if (reset) begin
      if (en_end) en_cnt <= en_cnt + 1;
      if (cf_start && !p_start) begin
        blk_log[start_cnt % 8] <= cf_block;
        start_cnt <= start_cnt + 1;
      end
      if (cf_start && p_start && (cf_block !== p_blk || cf_iv !== p_iv))
        stab_err <= stab_err + 1;
      if (cf_start && msg_valid && msg_ready) comp_acc <= comp_acc + 1;
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_msg(input int n, input logic [31:0] w, input logic [31:0] lastw,
                          input logic [2:0] lb, input bit rnd);
    int i, t;
    i = 0;
    t = 0;
    while (i < n && t < 20000) begin
      @(negedge clk);
      msg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      msg_data  = (i == n - 1) ? lastw : w;
      msg_last  = (i == n - 1);
      msg_bytes = lb;
      if (msg_valid && msg_ready) i++;
      t++;
    end
    @(negedge clk);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    chk("send_words", 512'(i), 512'(n));
  endtask

  task automatic wait_en(input string tag, input int base);
    int t;
    t = 0;
    while (en_cnt == base && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk(tag, 512'(en_cnt - base), 512'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 512'(msg_ready), 512'd0);
    chk({tag, "_start"}, 512'(cf_start), 512'd0);
    chk({tag, "_iv"}, 512'(cf_iv), 512'(IV));
    chk({tag, "_blk"}, cf_block, 512'd0);
    chk({tag, "_hash"}, 512'(hashValue), 512'd0);
    chk({tag, "_en"}, 512'(en_end), 512'd0);
  endtask

  initial begin
    int sb, eb, t;
    logic [511:0] b1, b2;
    logic [255:0] exp_d;

    reset     = 1'b0;
    msg_data  = '0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_bytes = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // "abc"
    sb = start_cnt; eb = en_cnt;
    send_msg(1, 32'h0, 32'h61626300, 3'd3, 1'b0);
    wait_en("abc_en", eb);
    chk("abc_starts", 512'(start_cnt - sb), 512'd1);
    chk("abc_block", blk_log[sb % 8], {32'h61626380, 448'h0, 32'h18});
    chk("abc_digest", 512'(hashValue), 512'(D_ABC));

    // "abcd" x 16
    sb = start_cnt; eb = en_cnt;
    send_msg(16, 32'h61626364, 32'h61626364, 3'd4, 1'b0);
    wait_en("abcd_en", eb);
    chk("abcd_starts", 512'(start_cnt - sb), 512'd2);
    chk("abcd_block2", blk_log[(sb + 1) % 8], {32'h80000000, 448'h0, 32'h200});
    chk("abcd_digest", 512'(hashValue), 512'(D_ABCD));

    // Empty message; discarded last word carries junk that must not leak
    sb = start_cnt; eb = en_cnt;
    send_msg(1, 32'h0, 32'hdeadbeef, 3'd0, 1'b0);
    wait_en("empty_en", eb);
    chk("empty_starts", 512'(start_cnt - sb), 512'd1);
    chk("empty_block", blk_log[sb % 8], {32'h80000000, 480'h0});
    chk("empty_digest", 512'(hashValue), 512'(D_EMPTY));

    // 56 bytes: marker lands in word 14, length goes to a second block
    sb = start_cnt; eb = en_cnt;
    send_msg(14, 32'h61626364, 32'h61626364, 3'd4, 1'b0);
    wait_en("m56_en", eb);
    b1 = {{14{32'h61626364}}, 32'h80000000, 32'h0};
    b2 = {480'h0, 32'h1c0};
    exp_d = sm3_cf(sm3_cf(IV, b1), b2);
    chk("m56_starts", 512'(start_cnt - sb), 512'd2);
    chk("m56_block1", blk_log[sb % 8], b1);
    chk("m56_block2", blk_log[(sb + 1) % 8], b2);
    chk("m56_digest", 512'(hashValue), 512'(exp_d));

    // 55 bytes: everything fits in one block
    sb = start_cnt; eb = en_cnt;
    send_msg(14, 32'h61626364, 32'h61626364, 3'd3, 1'b0);
    wait_en("m55_en", eb);
    b1 = {{13{32'h61626364}}, 32'h61626380, 32'h0, 32'h1b8};
    chk("m55_starts", 512'(start_cnt - sb), 512'd1);
    chk("m55_block", blk_log[sb % 8], b1);
    chk("m55_digest", 512'(hashValue), 512'(sm3_cf(IV, b1)));

    // Backpressure plus slow core
    cf_lat = 64;
    sb = start_cnt; eb = en_cnt;
    send_msg(16, 32'h61626364, 32'h61626364, 3'd4, 1'b1);
    wait_en("stall_en", eb);
    chk("stall_starts", 512'(start_cnt - sb), 512'd2);
    chk("stall_digest", 512'(hashValue), 512'(D_ABCD));
    chk("stall_stable", 512'(stab_err), 512'd0);
    chk("stall_no_accept_in_comp", 512'(comp_acc), 512'd0);

    // Reset during the second compression, then a clean "abc"
    sb = start_cnt; eb = en_cnt;
    send_msg(16, 32'h61626364, 32'h61626364, 3'd4, 1'b0);
    t = 0;
    while (start_cnt - sb < 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_blk2", 512'(start_cnt - sb), 512'd2);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (80) @(negedge clk);
    chk("abort_no_en", 512'(en_cnt - eb), 512'd0);
    reset  = 1'b1;
    cf_lat = 2;
    repeat (2) @(negedge clk);
    sb = start_cnt; eb = en_cnt;
    send_msg(1, 32'h0, 32'h61626300, 3'd3, 1'b0);
    wait_en("rerun_en", eb);
    chk("rerun_starts", 512'(start_cnt - sb), 512'd1);
    chk("rerun_digest", 512'(hashValue), 512'(D_ABC));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
